riscv_test_monitor: RTL and testbench
=====================================

Name: riscv_test_monitor

Overview:
Synthesizable end-of-test monitor that watches the core's retirement and store traffic and decides pass/fail/timeout/hang for riscv-tests programs. Generalises the fixed "PC reaches 0x44, check x3" check: pass PC, tohost address, timeout and detection mode are all parameters. Adds a cycle counter and self-loop hang detection. Sits beside the Core in the simulation top; its outputs drive result reporting and $finish.

Parameters:
XLEN, 32, data/address width of observed buses
MODE, 0, 0 = PC/gp mode (end at PASS_PC, verdict from gp); 1 = tohost mode (end on store to TOHOST_ADDR)
PASS_PC, 32'h44, retire PC that ends the test in MODE 0
TOHOST_ADDR, 32'h1000, store address that ends the test in MODE 1
TIMEOUT, 5000, cycles in RUN before TIMEOUT verdict
STALL_LIMIT, 64, consecutive same-PC retirements giving HANG verdict
CNT_W, 32, width of cycle counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse: clear counters, enter RUN
retire_valid  in  1  instruction retired this cycle
retire_pc  in  XLEN  PC of retired instruction
gp_value  in  XLEN  current value of x3 (gp)
mem_we  in  1  data-memory store strobe
mem_addr  in  XLEN  store address
mem_wdata  in  XLEN  store data
state  out  3  IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4, HANG=5
done  out  1  high in any terminal state (2..5)
done_pulse  out  1  one cycle high on entry to a terminal state
pass  out  1  high only in PASS
fail_code  out  XLEN-1  failing test number (verdict value >> 1), 0 otherwise
cycles  out  CNT_W  cycles spent in RUN

Behaviour:
- rst low (async): state=IDLE, done=0, done_pulse=0, pass=0, fail_code=0, cycles=0, stall counter=0, last-PC register=0.
- IDLE: ignore all monitored inputs; start -> RUN next edge with cycles=0, stall count=0.
- RUN: cycles += 1 every edge, saturating at 2^CNT_W-1.
- MODE 0 end event: retire_valid && retire_pc==PASS_PC. gp_value==1 -> PASS; else FAIL with fail_code=gp_value>>1.
- MODE 1 end event: mem_we && mem_addr==TOHOST_ADDR. wdata==1 -> PASS; wdata[0]==1 && wdata!=1 -> FAIL, fail_code=wdata>>1; wdata[0]==0 -> ignored, stay RUN.
- Timeout: entering the edge where cycles would reach TIMEOUT with no end event -> TIMEOUT (i.e. TIMEOUT cycles of RUN max).
- Hang: on retire_valid, if retire_pc == last retired PC then stall count += 1 else stall count = 1; last PC updated. Stall count reaching STALL_LIMIT -> HANG.
- Priority same cycle: end event > HANG > TIMEOUT.
- Verdict registered: state/pass/fail_code/done update one edge after the event cycle; done_pulse high exactly that one cycle.
- Terminal states sticky; cycles frozen; inputs ignored. start in terminal state -> RUN (full clear, fail_code=0, pass=0). start in RUN restarts the same way.
- start and end event same cycle in RUN: start wins.
- rst asserted mid-RUN: immediate return to reset values, no done_pulse.

Optional Feature:
TEST_MON_STALL_EN: defined -> hang detection as above, state 5 reachable. Not defined -> stall counter and last-PC register not built; HANG never entered; priority reduces to end event > TIMEOUT.

Test Plan:
- MODE 0, start, retire pc 0x44 at cycle 20 with gp=1 -> next edge state=2, pass=1, done_pulse 1 cycle, cycles=21, fail_code=0.
- MODE 0, retire pc 0x44 with gp=7 -> state=3, pass=0, fail_code=3.
- MODE 1, store 0x0 to 0x1000 (ignored, stays RUN), then store 0x0B -> state=3, fail_code=5; then start -> state=1, fail_code=0, cycles=0.
- TIMEOUT=100, no end event -> state=4 after exactly 100 RUN cycles, cycles=100; end event on that same cycle -> PASS instead.
- TEST_MON_STALL_EN, STALL_LIMIT=4, retire pc 0x80 four times -> state=5; retire 0x80,0x84,0x80... -> stays RUN; macro undefined -> same stimulus stays RUN.
- Drop rst mid-RUN at cycle 50 -> outputs return to reset values asynchronously, state=0, no done_pulse.

Source files
------------

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor for riscv-tests programs: PC/gp or tohost verdicts, cycle count, timeout.
// Self-loop hang detection is built only when TEST_MON_STALL_EN is defined.
module riscv_test_monitor #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     MODE        = 0,
  parameter logic [XLEN-1:0] PASS_PC     = 32'h44,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h1000,
  parameter int unsigned     TIMEOUT     = 5000,
  parameter int unsigned     STALL_LIMIT = 64,
  parameter int unsigned     CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             retire_valid,
  input  logic [XLEN-1:0]  retire_pc,
  input  logic [XLEN-1:0]  gp_value,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic [2:0]       state,
  output logic             done,
  output logic             done_pulse,
  output logic             pass,
  output logic [XLEN-2:0]  fail_code,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_HANG    = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  if (TIMEOUT == 0 || STALL_LIMIT == 0) begin : g_cfg_check
    $error("riscv_test_monitor: TIMEOUT and STALL_LIMIT must be non-zero");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d, cycles_inc;
  logic [XLEN-2:0]  fail_code_q, fail_code_d;
  logic             done_pulse_q, done_pulse_d;
  logic             in_run;
  logic             end_hit, end_pass, end_fail;
  logic [XLEN-1:0]  end_val;
  logic             hang_hit, tmo_hit;

  assign in_run = (state_q == ST_RUN);

  // End event: retire at PASS_PC (verdict in gp) or an odd store to tohost.
  always_comb begin
    end_hit = 1'b0;
    end_val = '0;
    if (MODE == 0) begin
      end_hit = retire_valid && (retire_pc == PASS_PC);
      end_val = gp_value;
    end else begin
      end_hit = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
      end_val = mem_wdata;
    end
  end

  assign end_pass = end_hit && (end_val == XLEN'(1));
  assign end_fail = end_hit && !end_pass;

  assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);
  assign tmo_hit    = (cycles_inc >= TIMEOUT_C);

`ifdef TEST_MON_STALL_EN
  localparam int unsigned   SW        = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

  logic [SW-1:0]   stall_q, stall_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;

  always_comb begin
    stall_d   = stall_q;
    last_pc_d = last_pc_q;
    if (start) begin
      stall_d   = '0;
      last_pc_d = '0;
    end else if (in_run && retire_valid) begin
      last_pc_d = retire_pc;
      if (retire_pc != last_pc_q) begin
        stall_d = SW'(1);
      end else if (stall_q != STALL_MAX) begin
        stall_d = stall_q + SW'(1);
      end
    end
  end

  assign hang_hit = in_run && retire_valid && (stall_d == STALL_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q   <= '0;
      last_pc_q <= '0;
    end else begin
      stall_q   <= stall_d;
      last_pc_q <= last_pc_d;
    end
  end
`else
  assign hang_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // start outranks every verdict; terminal states only leave on start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start)         state_d = ST_RUN;
        else if (end_pass) state_d = ST_PASS;
        else if (end_fail) state_d = ST_FAIL;
        else if (hang_hit) state_d = ST_HANG;
        else if (tmo_hit)  state_d = ST_TIMEOUT;
      end
      default: begin
        if (start) state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    cycles_d     = cycles_q;
    fail_code_d  = fail_code_q;
    done_pulse_d = 1'b0;
    if (start) begin
      cycles_d    = '0;
      fail_code_d = '0;
    end else if (in_run) begin
      cycles_d     = cycles_inc;
      if (end_fail) fail_code_d = end_val[XLEN-1:1];
      done_pulse_d = (state_d != ST_RUN);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_q     <= '0;
      fail_code_q  <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      cycles_q     <= cycles_d;
      fail_code_q  <= fail_code_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  always_comb begin
    state = state_q;
    done  = 1'b0;
    pass  = 1'b0;
    case (state_q)
      ST_PASS: begin
        done = 1'b1;
        pass = 1'b1;
      end
      ST_FAIL, ST_TIMEOUT, ST_HANG: done = 1'b1;
      default: ;
    endcase
  end

  assign done_pulse = done_pulse_q;
  assign fail_code  = fail_code_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: a PC/gp-mode and a tohost-mode instance share one stimulus stream.
module tb_riscv_test_monitor;
`ifdef TEST_MON_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  localparam int unsigned TMO    = 100;
  localparam int unsigned SL     = 4;
  localparam logic [31:0] PC_END = 32'h44;
  localparam logic [31:0] TOHOST = 32'h1000;
  localparam int          HS     = STALL_EN ? 5 : 1;
  localparam int          HP     = STALL_EN ? 1 : 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, retire_valid, mem_we;
  logic [31:0] retire_pc, gp_value, mem_addr, mem_wdata;
  logic [2:0]  state0, state1;
  logic        done0, done1, dp0, dp1, pass0, pass1;
  logic [30:0] fc0, fc1;
  logic [31:0] cyc0, cyc1;

  riscv_test_monitor #(
    .XLEN(32), .MODE(0), .PASS_PC(PC_END), .TOHOST_ADDR(TOHOST),
    .TIMEOUT(TMO), .STALL_LIMIT(SL), .CNT_W(32)
  ) u_mon_pc (
    .clk(clk), .rst(rst), .start(start), .retire_valid(retire_valid),
    .retire_pc(retire_pc), .gp_value(gp_value), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .state(state0), .done(done0),
    .done_pulse(dp0), .pass(pass0), .fail_code(fc0), .cycles(cyc0)
  );

  riscv_test_monitor #(
    .XLEN(32), .MODE(1), .PASS_PC(PC_END), .TOHOST_ADDR(TOHOST),
    .TIMEOUT(TMO), .STALL_LIMIT(SL), .CNT_W(32)
  ) u_mon_host (
    .clk(clk), .rst(rst), .start(start), .retire_valid(retire_valid),
    .retire_pc(retire_pc), .gp_value(gp_value), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .state(state1), .done(done1),
    .done_pulse(dp1), .pass(pass1), .fail_code(fc1), .cycles(cyc1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: verdict per instance plus the recent retire history since start.
  int          m_st[2];
  int unsigned m_cyc[2];
  logic [30:0] m_fc[2];
  bit          m_dp[2];
  logic [31:0] hist[$];

  typedef struct {
    int rep; int s; int rv; int pc; int gp; int we; int a; int wd;
    int st0; int st1; int fc0; int fc1; int c0; int c1; int d0; int d1;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int end_verdict(input int mode, input bit rv, input logic [31:0] pc,
                                     input logic [31:0] gp, input bit we, input logic [31:0] a,
                                     input logic [31:0] wd, output logic [30:0] code);
    logic [31:0] v;
    code = '0;
    if (mode == 0) begin
      if (!(rv && pc == PC_END)) return 0;
      v = gp;
    end else begin
      if (!(we && a == TOHOST) || (wd % 2) == 0) return 0;
      v = wd;
    end
    code = 31'(v >> 1);
    return (v == 32'd1) ? 2 : 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_cyc[k] = 0; m_fc[k] = '0; m_dp[k] = 1'b0;
    end
    hist.delete();
  endtask

  task automatic model_step(input bit s, input bit rv, input logic [31:0] pc, input logic [31:0] gp,
                            input bit we, input logic [31:0] a, input logic [31:0] wd);
    bit          hang;
    int          v;
    logic [30:0] code;
    if (s) hist.delete();
    else if (rv) begin
      hist.push_back(pc);
      if (hist.size() > SL) void'(hist.pop_front());
    end
    hang = STALL_EN && rv && !s && (hist.size() == SL);
    foreach (hist[i]) if (hist[i] != hist[0]) hang = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_dp[k] = 1'b0;
      if (s) begin
        m_st[k] = 1; m_cyc[k] = 0; m_fc[k] = '0;
      end else if (m_st[k] == 1) begin
        if (m_cyc[k] != 32'hFFFF_FFFF) m_cyc[k]++;
        v = end_verdict(k, rv, pc, gp, we, a, wd, code);
        if (v != 0) begin
          m_st[k] = v;
          if (v == 3) m_fc[k] = code;
        end else if (hang) m_st[k] = 5;
        else if (m_cyc[k] >= TMO) m_st[k] = 4;
        m_dp[k] = (m_st[k] != 1);
      end
    end
  endtask

  task automatic compare_all();
    check("pc.state", state0, m_st[0]);      check("host.state", state1, m_st[1]);
    check("pc.done", done0, m_st[0] >= 2);   check("host.done", done1, m_st[1] >= 2);
    check("pc.done_pulse", dp0, m_dp[0]);    check("host.done_pulse", dp1, m_dp[1]);
    check("pc.pass", pass0, m_st[0] == 2);   check("host.pass", pass1, m_st[1] == 2);
    check("pc.fail_code", fc0, m_fc[0]);     check("host.fail_code", fc1, m_fc[1]);
    check("pc.cycles", cyc0, m_cyc[0]);      check("host.cycles", cyc1, m_cyc[1]);
  endtask

  task automatic step(input bit s, input bit rv, input logic [31:0] pc, input logic [31:0] gp,
                      input bit we, input logic [31:0] a, input logic [31:0] wd);
    start = s; retire_valid = rv; retire_pc = pc; gp_value = gp;
    mem_we = we; mem_addr = a; mem_wdata = wd;
    model_step(s, rv, pc, gp, we, a, wd);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic add(input int rep, input int s, input int rv, input int pc, input int gp,
                     input int we, input int a, input int wd, input int st0, input int st1,
                     input int fc0v, input int fc1v, input int c0, input int c1,
                     input int d0, input int d1);
    vec_t v;
    v.rep = rep; v.s = s; v.rv = rv; v.pc = pc; v.gp = gp; v.we = we; v.a = a; v.wd = wd;
    v.st0 = st0; v.st1 = st1; v.fc0 = fc0v; v.fc1 = fc1v; v.c0 = c0; v.c1 = c1;
    v.d0 = d0; v.d1 = d1;
    tbl.push_back(v);
  endtask

  logic [31:0] pc_r;

  initial begin
    rst = 1'b0; start = 1'b0; retire_valid = 1'b0; retire_pc = '0; gp_value = '0;
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    pc_r = 32'h80;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;

    //  rep s rv pc     gp we a       wd     st0 st1 fc0 fc1 c0   c1   d0  d1
    add(1,  1, 0, 0,     0, 0, 0,      0,     1,  1,  0,  0,  0,   0,   0,  0);
    add(20, 0, 0, 0,     0, 0, 0,      0,     1,  1,  0,  0,  20,  20,  0,  0);
    add(1,  0, 1, 'h44,  1, 0, 0,      0,     2,  1,  0,  0,  21,  21,  1,  0);
    add(1,  0, 0, 0,     0, 0, 0,      0,     2,  1,  0,  0,  21,  22,  0,  0);
    add(1,  1, 0, 0,     0, 0, 0,      0,     1,  1,  0,  0,  0,   0,   0,  0);
    add(1,  0, 1, 'h44,  7, 0, 0,      0,     3,  1,  3,  0,  1,   1,   1,  0);
    add(1,  0, 0, 0,     0, 1, 'h1000, 0,     3,  1,  3,  0,  1,   2,   0,  0);
    add(1,  0, 0, 0,     0, 1, 'h1000, 'h0B,  3,  3,  3,  5,  1,   3,   0,  1);
    add(1,  1, 0, 0,     0, 0, 0,      0,     1,  1,  0,  0,  0,   0,   0,  0);
    add(99, 0, 0, 0,     0, 0, 0,      0,     1,  1,  0,  0,  99,  99,  0,  0);
    add(1,  0, 0, 0,     0, 0, 0,      0,     4,  4,  0,  0,  100, 100, 1,  1);
    add(1,  1, 0, 0,     0, 0, 0,      0,     1,  1,  0,  0,  0,   0,   0,  0);
    add(99, 0, 0, 0,     0, 0, 0,      0,     1,  1,  0,  0,  99,  99,  0,  0);
    add(1,  0, 1, 'h44,  1, 0, 0,      0,     2,  4,  0,  0,  100, 100, 1,  1);
    add(1,  1, 0, 0,     0, 0, 0,      0,     1,  1,  0,  0,  0,   0,   0,  0);
    add(4,  0, 1, 'h80,  0, 0, 0,      0,     HS, HS, 0,  0,  4,   4,   HP, HP);
    add(1,  1, 0, 0,     0, 0, 0,      0,     1,  1,  0,  0,  0,   0,   0,  0);
    add(1,  0, 1, 'h80,  0, 0, 0,      0,     1,  1,  0,  0,  1,   1,   0,  0);
    add(1,  0, 1, 'h84,  0, 0, 0,      0,     1,  1,  0,  0,  2,   2,   0,  0);
    add(3,  0, 1, 'h80,  0, 0, 0,      0,     1,  1,  0,  0,  5,   5,   0,  0);
    add(1,  0, 1, 'h80,  0, 0, 0,      0,     HS, HS, 0,  0,  6,   6,   HP, HP);
    add(1,  1, 1, 'h44,  1, 1, 'h1000, 1,     1,  1,  0,  0,  0,   0,   0,  0);
    add(1,  0, 1, 'h44,  9, 1, 'h1000, 1,     3,  2,  4,  0,  1,   1,   1,  1);
    add(1,  0, 1, 'h44,  1, 1, 'h1000, 3,     3,  2,  4,  0,  1,   1,   0,  0);
    add(1,  1, 0, 0,     0, 0, 0,      0,     1,  1,  0,  0,  0,   0,   0,  0);
    add(3,  0, 1, 'h80,  0, 0, 0,      0,     1,  1,  0,  0,  3,   3,   0,  0);
    add(1,  0, 1, 'h80,  0, 1, 'h1000, 1,     HS, 2,  0,  0,  4,   4,   HP, 1);

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rep; r++)
        step(tbl[i].s != 0, tbl[i].rv != 0, tbl[i].pc, tbl[i].gp,
             tbl[i].we != 0, tbl[i].a, tbl[i].wd);
      check($sformatf("row%0d pc.state", i), state0, tbl[i].st0);
      check($sformatf("row%0d host.state", i), state1, tbl[i].st1);
      check($sformatf("row%0d pc.fail_code", i), fc0, tbl[i].fc0);
      check($sformatf("row%0d host.fail_code", i), fc1, tbl[i].fc1);
      check($sformatf("row%0d pc.cycles", i), cyc0, tbl[i].c0);
      check($sformatf("row%0d host.cycles", i), cyc1, tbl[i].c1);
      check($sformatf("row%0d pc.done_pulse", i), dp0, tbl[i].d0);
      check($sformatf("row%0d host.done_pulse", i), dp1, tbl[i].d1);
    end

    // Asynchronous reset in the middle of a run, then held across an edge.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    for (int c = 0; c < 50; c++) step(1'b0, 1'b1, 32'h100 + 32'(4 * c), '0, 1'b0, '0, '0);
    check("midrun pc.cycles", cyc0, 50);
    check("midrun pc.state", state0, 1);
    #2 rst = 1'b0;
    #1;
    check("async pc.state", state0, 0);   check("async host.state", state1, 0);
    check("async pc.cycles", cyc0, 0);    check("async host.cycles", cyc1, 0);
    check("async pc.done", done0, 0);     check("async pc.done_pulse", dp0, 0);
    check("async pc.pass", pass0, 0);     check("async pc.fail_code", fc0, 0);
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      bit          s, rv, we;
      int          phase, sel;
      logic [31:0] gp, a, wd;
      phase = (n / 500) % 3;
      s  = (phase == 1) ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 59) == 0);
      rv = ($urandom_range(0, 1) == 1);
      sel = $urandom_range(0, 39);
      if (sel == 0) pc_r = PC_END;
      else if (phase == 1 || (phase == 2 && sel < 20) || sel < 7)
        pc_r = 32'h80 + 32'(4 * $urandom_range(0, 3));
      gp = ($urandom_range(0, 1) == 1) ? 32'd1 : 32'($urandom_range(0, 15));
      we = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       a = TOHOST;
        1:       a = TOHOST + 32'd4;
        default: a = $urandom;
      endcase
      wd = ($urandom_range(0, 2) == 0) ? 32'd1 : 32'($urandom_range(0, 31));
      step(s, rv, pc_r, gp, we, a, wd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
